// File: rtl/gate_port_pkg.sv
// Shared types and constants for the multi-gate open/close controller:
// gate state encoding, default parameters and the lowest-index grant helper.
package gate_port_pkg;

  typedef enum logic [1:0] {
    CLOSED  = 2'b00,
    PENDING = 2'b01,
    OPEN    = 2'b10
  } gate_state_t;

  localparam int MAX_PORTS      = 8;
  localparam int IDX_W          = $clog2(MAX_PORTS);
  localparam int DEF_N_PORTS    = 2;
  localparam int DEF_DEB_CYCLES = 4;
  localparam int DEF_TIMEOUT    = 1000;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } grant_t;

  // Lowest set bit of req wins; valid is low when nothing is requesting.
  function automatic grant_t lowest_index(input logic [MAX_PORTS-1:0] req);
    grant_t g;
    g = '0;
    for (int i = MAX_PORTS - 1; i >= 0; i--) begin
      if (req[i]) begin
        g.valid = 1'b1;
        g.idx   = IDX_W'(i);
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/gate_debounce.sv
// One switch channel: 2-flop synchroniser, consecutive-cycle debounce counter
// and a registered one-cycle toggle pulse for every accepted change.
module gate_debounce
  import gate_port_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw_async,
  output logic toggle
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          stable_q, stable_d;
  logic          toggle_q, toggle_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The count restarts whenever the synchronised input agrees with the stable value.
  always_comb begin
    stable_d = stable_q;
    toggle_d = 1'b0;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
        toggle_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      toggle_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sw_async;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      toggle_q <= toggle_d;
      cnt_q    <= cnt_d;
    end
  end

  assign toggle = toggle_q;

endmodule

// File: rtl/gate_port_ctrl.sv
// Multi-gate controller: per-channel CLOSED/PENDING/OPEN FSMs with equalisation
// interlock and single-open mutual exclusion. GATE_AUTO_CLOSE_EN adds auto-close.
module gate_port_ctrl
  import gate_port_pkg::*;
#(
  parameter int N_PORTS    = DEF_N_PORTS,
  parameter int DEB_CYCLES = DEF_DEB_CYCLES,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic [N_PORTS-1:0]      SwitchFlip,
  input  logic [N_PORTS-1:0]      EVState,
  output logic [N_PORTS-1:0]      OpenClose,
  output logic [N_PORTS-1:0]      Pending,
  output logic                    Busy,
  output logic [N_PORTS-1:0][1:0] dbg_state
);

  logic [N_PORTS-1:0] toggle;
  logic [N_PORTS-1:0] open_now, cand, grant, expire;
  logic               any_open;
  grant_t             win;

  gate_state_t        state_q [N_PORTS];
  gate_state_t        state_d [N_PORTS];
  logic [N_PORTS-1:0] open_q, open_d, pend_q, pend_d;
  logic               busy_q, busy_d;

  for (genvar g = 0; g < N_PORTS; g++) begin : g_deb
    gate_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk     (Clock),
      .rst_n   (Reset),
      .sw_async(SwitchFlip[g]),
      .toggle  (toggle[g])
    );
  end

  // A PENDING channel that is toggled is cancelling, so it is not a candidate.
  always_comb begin
    open_now = '0;
    cand     = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      open_now[i] = (state_q[i] == OPEN);
      cand[i]     = !EVState[i] &&
                    (((state_q[i] == CLOSED) && toggle[i]) ||
                     ((state_q[i] == PENDING) && !toggle[i]));
    end
  end

  assign any_open = |open_now;
  assign win      = lowest_index(MAX_PORTS'(cand));

  // No grant while anything is open, so a closer and an opener never share an edge.
  always_comb begin
    grant = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      grant[i] = !any_open && win.valid && (win.idx == IDX_W'(i));
    end
  end

`ifdef GATE_AUTO_CLOSE_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] tmr_q [N_PORTS];
  logic [TW-1:0] tmr_d [N_PORTS];

  // tmr_q counts completed open cycles; the edge that would reach TIMEOUT closes.
  always_comb begin
    expire = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      expire[i] = open_now[i] && (tmr_q[i] == T_LAST);
      tmr_d[i]  = (open_now[i] && (state_d[i] == OPEN)) ? tmr_q[i] + 1'b1 : '0;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < N_PORTS; i++) tmr_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_PORTS; i++) tmr_q[i] <= tmr_d[i];
    end
  end
`else
  assign expire = '0;
`endif

  always_comb begin
    open_d = '0;
    pend_d = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      state_d[i] = state_q[i];
      case (state_q[i])
        CLOSED:  if (toggle[i]) state_d[i] = grant[i] ? OPEN : PENDING;
        PENDING: begin
          if (toggle[i])     state_d[i] = CLOSED;
          else if (grant[i]) state_d[i] = OPEN;
        end
        OPEN:    if (EVState[i] || toggle[i] || expire[i]) state_d[i] = CLOSED;
        default: state_d[i] = CLOSED;
      endcase
      open_d[i] = (state_d[i] == OPEN);
      pend_d[i] = (state_d[i] == PENDING);
    end
    busy_d = |open_d;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < N_PORTS; i++) state_q[i] <= CLOSED;
      open_q <= '0;
      pend_q <= '0;
      busy_q <= 1'b0;
    end else begin
      for (int i = 0; i < N_PORTS; i++) state_q[i] <= state_d[i];
      open_q <= open_d;
      pend_q <= pend_d;
      busy_q <= busy_d;
    end
  end

  always_comb begin
    for (int i = 0; i < N_PORTS; i++) dbg_state[i] = state_q[i];
  end

  assign OpenClose = open_q;
  assign Pending   = pend_q;
  assign Busy      = busy_q;

endmodule

// File: tb/tb_gate_port_ctrl.sv
// Bench for gate_port_ctrl: directed vector table, reset/timeout sequences and
// randomized switch/inhibit traffic checked against a behavioural model.
module tb_gate_port_ctrl;

  localparam int N   = 2;
  localparam int DEB = 4;
  localparam int TMO = 10;
`ifdef GATE_AUTO_CLOSE_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic              Clock = 1'b0;
  logic              Reset;
  logic [N-1:0]      SwitchFlip, EVState, OpenClose, Pending;
  logic              Busy;
  logic [N-1:0][1:0] dbg_state;

  int n_total = 0;
  int n_pass  = 0;

  gate_port_ctrl #(.N_PORTS(N), .DEB_CYCLES(DEB), .TIMEOUT(TMO)) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .SwitchFlip(SwitchFlip),
    .EVState   (EVState),
    .OpenClose (OpenClose),
    .Pending   (Pending),
    .Busy      (Busy),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 Clock = ~Clock;

  // ---------------- reference model ----------------
  // Gate state is held as "which gate is open" plus a set of waiting gates.
  logic [N-1:0] hist_q[$];
  logic [N-1:0] m_stable, m_tog, m_pend;
  int           m_open, m_age;

  task automatic model_reset();
    hist_q.delete();
    repeat (DEB + 2) hist_q.push_back('0);
    m_stable = '0;
    m_tog    = '0;
    m_pend   = '0;
    m_open   = -1;
    m_age    = 0;
  endtask

  task automatic model_step();
    logic [N-1:0] cand, next_pend;
    int           next_open;
    bit           was_open, all_diff;
    was_open  = (m_open >= 0);
    next_open = m_open;
    next_pend = m_pend;
    cand      = '0;
    if (was_open) begin
      if (EVState[m_open] || m_tog[m_open] || (AUTO && (m_age + 1 == TMO))) next_open = -1;
    end
    for (int i = 0; i < N; i++) begin
      if (i != m_open) begin
        if (m_pend[i]) begin
          if (m_tog[i]) next_pend[i] = 1'b0;
          else if (!EVState[i]) cand[i] = 1'b1;
        end else if (m_tog[i]) begin
          if (!EVState[i]) cand[i] = 1'b1;
          else next_pend[i] = 1'b1;
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      if (cand[i]) begin
        if (!was_open && next_open < 0) begin
          next_open    = i;
          next_pend[i] = 1'b0;
        end else begin
          next_pend[i] = 1'b1;
        end
      end
    end
    m_age  = (was_open && next_open == m_open) ? m_age + 1 : 0;
    m_open = next_open;
    m_pend = next_pend;
    // Debounce: the value seen by the FSM at edge t is the switch sampled at t-2.
    hist_q.push_back(SwitchFlip);
    m_tog = '0;
    for (int i = 0; i < N; i++) begin
      all_diff = 1'b1;
      for (int k = 0; k < DEB; k++) begin
        if (hist_q[hist_q.size() - 3 - k][i] == m_stable[i]) all_diff = 1'b0;
      end
      if (all_diff) begin
        m_stable[i] = ~m_stable[i];
        m_tog[i]    = 1'b1;
      end
    end
    if (hist_q.size() > DEB + 8) void'(hist_q.pop_front());
  endtask

  function automatic logic [N-1:0] model_open_vec();
    logic [N-1:0] v;
    v = '0;
    if (m_open >= 0) v[m_open] = 1'b1;
    return v;
  endfunction

  // ---------------- driver / checker tasks ----------------
  task automatic tick();
    @(posedge Clock);
    if (Reset) model_step();
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic check_outs(input string tag, input logic [N-1:0] e_open,
                            input logic [N-1:0] e_pend, input logic e_busy);
    check({tag, "_open"}, 32'(OpenClose), 32'(e_open));
    check({tag, "_pend"}, 32'(Pending),   32'(e_pend));
    check({tag, "_busy"}, 32'(Busy),      32'(e_busy));
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [N-1:0] sw;
    logic [N-1:0] ev;
    int           hold;
    logic [N-1:0] exp_open;
    logic [N-1:0] exp_pend;
    logic         exp_busy;
  } vec_t;

  vec_t vecs[15];

  initial begin
    vecs[0]  = '{2'b00, 2'b00, 3, 2'b00, 2'b00, 1'b0};
    vecs[1]  = '{2'b01, 2'b00, 6, 2'b00, 2'b00, 1'b0};  // one edge short of latency
    vecs[2]  = '{2'b01, 2'b00, 1, 2'b01, 2'b00, 1'b1};  // opens DEB+3 edges after change
    vecs[3]  = '{2'b11, 2'b00, 2, 2'b01, 2'b00, 1'b1};
    vecs[4]  = '{2'b10, 2'b00, 5, 2'b01, 2'b10, 1'b1};  // gate 1 waits on exclusion
    vecs[5]  = '{2'b10, 2'b00, 2, 2'b00, 2'b10, 1'b0};  // gate 0 closes, nobody open
    vecs[6]  = '{2'b10, 2'b00, 1, 2'b10, 2'b00, 1'b1};  // gate 1 enters one edge later
    vecs[7]  = '{2'b00, 2'b00, 2, 2'b10, 2'b00, 1'b1};  // 2-cycle glitch on gate 1
    vecs[8]  = '{2'b10, 2'b00, 6, 2'b10, 2'b00, 1'b1};
    vecs[9]  = '{2'b10, 2'b10, 1, 2'b00, 2'b00, 1'b0};  // inhibit forces close next edge
    vecs[10] = '{2'b11, 2'b01, 7, 2'b00, 2'b01, 1'b0};  // toggle while inhibited
    vecs[11] = '{2'b11, 2'b00, 1, 2'b01, 2'b00, 1'b1};  // opens when inhibit falls
    vecs[12] = '{2'b10, 2'b00, 7, 2'b00, 2'b00, 1'b0};
    vecs[13] = '{2'b01, 2'b00, 7, 2'b01, 2'b10, 1'b1};  // simultaneous: lowest wins
    vecs[14] = '{2'b01, 2'b00, 3, 2'b01, 2'b10, 1'b1};
  end

  // ---------------- main sequence ----------------
  initial begin
    Reset      = 1'b0;
    SwitchFlip = '0;
    EVState    = '0;
    model_reset();
    repeat (3) tick();
    check_outs("reset", 2'b00, 2'b00, 1'b0);
    #2 Reset = 1'b1;

    for (int r = 0; r < 15; r++) begin
      SwitchFlip = vecs[r].sw;
      EVState    = vecs[r].ev;
      repeat (vecs[r].hold) tick();
      check_outs($sformatf("vec%0d", r), vecs[r].exp_open, vecs[r].exp_pend, vecs[r].exp_busy);
    end

    // Switch already high at reset release.
    Reset = 1'b0;
    model_reset();
    SwitchFlip = 2'b01;
    EVState    = 2'b00;
    repeat (2) tick();
    check_outs("held_in_reset", 2'b00, 2'b00, 1'b0);
    #2 Reset = 1'b1;
    repeat (6) tick();
    check_outs("held_early", 2'b00, 2'b00, 1'b0);
    tick();
    check_outs("held_open", 2'b01, 2'b00, 1'b1);

    // Reset mid-debounce while a gate is open: outputs drop at once,
    // and the stale partial count must not shorten the next acceptance.
    SwitchFlip = 2'b00;
    repeat (3) tick();
    #2 Reset = 1'b0;
    model_reset();
    #1 check_outs("async_reset", 2'b00, 2'b00, 1'b0);
    SwitchFlip = 2'b01;
    tick();
    #2 Reset = 1'b1;
    repeat (6) tick();
    check_outs("redeb_early", 2'b00, 2'b00, 1'b0);
    tick();
    check_outs("redeb_open", 2'b01, 2'b00, 1'b1);

    // Open duration: auto-close after TMO cycles, otherwise persists.
    for (int j = 1; j < TMO; j++) begin
      tick();
      check($sformatf("tmo_hold%0d", j), 32'(OpenClose), 32'h1);
    end
    tick();
    check("tmo_edge", 32'(OpenClose), AUTO ? 32'h0 : 32'h1);
    repeat (10) tick();
    check("tmo_after", 32'(OpenClose), AUTO ? 32'h0 : 32'h1);
    check("tmo_after_busy", 32'(Busy), AUTO ? 32'h0 : 32'h1);

    // Randomized traffic against the model.
    Reset = 1'b0;
    model_reset();
    SwitchFlip = '0;
    EVState    = '0;
    tick();
    #2 Reset = 1'b1;
    for (int c = 0; c < 800; c++) begin
      int idx;
      if ($urandom_range(0, 11) == 0) begin
        idx = $urandom_range(0, N - 1);
        SwitchFlip[idx] = ~SwitchFlip[idx];
      end
      if ($urandom_range(0, 19) == 0) begin
        idx = $urandom_range(0, N - 1);
        EVState[idx] = ~EVState[idx];
      end
      tick();
      check_outs($sformatf("rnd%0d", c), model_open_vec(), m_pend, (m_open >= 0));
      check($sformatf("rnd%0d_excl", c), 32'($countones(OpenClose) <= 1), 32'h1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
